// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the two-digit multiplexed seven-segment scanner.
package seg_scan_driver_pkg;
  localparam int DIV_W_DEF = 10;
  localparam int BLANK_DEF = 16;

  // Segment patterns for hex 0..F, segment a = bit 0 .. g = bit 6
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational hex nibble to seven-segment pattern lookup.
module hex7seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = HEX7SEG[hex];
endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit time-multiplexed seven-segment driver with per-slot blanking,
// frame-synchronous display update, leading-zero suppression and blink.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       lz_en,
  input  logic       blink,
  input  logic       seg_invert,
  output logic [1:0] digit_sel,
  output logic [6:0] segments,
  output logic       frame_tick
);
  logic [DIV_W-1:0] cnt;
  logic             act;
  logic [7:0]       disp, pend;
  logic             pend_full;
  logic [4:0]       fcnt;
  logic [1:0]       raw_sel;
  logic [6:0]       raw_seg;

  logic       wrap, boundary, blanking, seg_off;
  logic [3:0] nib;
  logic [6:0] seg_lut;

  assign wrap     = &cnt;
  assign boundary = wrap & act;
  assign blanking = cnt < DIV_W'(BLANK);
  assign nib      = act ? disp[7:4] : disp[3:0];
  assign seg_off  = blanking | (blink & fcnt[4]) | (lz_en & act & (disp[7:4] == 4'h0));

  hex7seg u_hex (.hex(nib), .seg(seg_lut));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      act        <= 1'b0;
      disp       <= 8'h00;
      pend       <= 8'h00;
      pend_full  <= 1'b0;
      fcnt       <= 5'd0;
      raw_sel    <= 2'b00;
      raw_seg    <= 7'h00;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + DIV_W'(1);
      if (wrap) act <= ~act;
      if (boundary) fcnt <= fcnt + 5'd1;
      frame_tick <= boundary;
      raw_sel    <= blanking ? 2'b00 : {act, ~act};
      raw_seg    <= seg_off ? 7'h00 : seg_lut;
      // A full pend blocks new accepts, so boundary load and accept never collide
      if (boundary && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (in_valid && !pend_full) begin
        pend      <= in_data;
        pend_full <= 1'b1;
      end
    end
  end

  assign in_ready  = ~pend_full;
  assign digit_sel = raw_sel ^ {2{seg_invert}};
  assign segments  = raw_seg ^ {7{seg_invert}};
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-index model.
module tb_seg_scan_driver;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, lz_en, blink, seg_invert;
  logic [7:0] in_data;
  logic       in_ready, frame_tick;
  logic [1:0] digit_sel;
  logic [6:0] segments;

  int tests = 0;
  int fails = 0;

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: n = edges since reset release; position in slot/frame derived arithmetically
  int         n;
  logic [7:0] m_disp, m_pend;
  logic       m_full;

  seg_scan_driver #(.DIV_W(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lz_en(lz_en), .blink(blink), .seg_invert(seg_invert), .digit_sel(digit_sel),
    .segments(segments), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    int cpos, apos, frame;
    logic bnd, e_tick;
    logic [1:0] es;
    logic [6:0] eg;
    logic [3:0] nibm;
    in_valid = v;
    in_data  = d;
    cpos  = n % 16;
    apos  = (n / 16) % 2;
    frame = (n / 32) % 32;
    bnd   = (n % 32) == 31;
    es    = (cpos < 2) ? 2'b00 : ((apos == 1) ? 2'b10 : 2'b01);
    nibm  = (apos == 1) ? m_disp[7:4] : m_disp[3:0];
    if (cpos < 2 || (blink && frame >= 16) || (lz_en && apos == 1 && m_disp[7:4] == 4'h0))
      eg = 7'h00;
    else
      eg = HEX[nibm];
    e_tick = bnd;
    @(posedge clk); #1;
    if (bnd && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (v && !m_full) begin
      m_pend = d;
      m_full = 1'b1;
    end
    n++;
    chk("digit_sel", {6'b0, digit_sel}, {6'b0, es ^ {2{seg_invert}}});
    chk("segments", {1'b0, segments}, {1'b0, eg ^ {7{seg_invert}}});
    chk("in_ready", {7'b0, in_ready}, {7'b0, ~m_full});
    chk("frame_tick", {7'b0, frame_tick}, {7'b0, e_tick});
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    m_disp = 8'h00; m_pend = 8'h00; m_full = 1'b0; n = 0;
    chk("rst_sel", {6'b0, digit_sel}, {6'b0, {2{seg_invert}}});
    chk("rst_seg", {1'b0, segments}, {1'b0, {7{seg_invert}}});
    chk("rst_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_tick", {7'b0, frame_tick}, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    lz_en = 1'b0; blink = 1'b0; seg_invert = 1'b1;
    do_reset(3);
    rst_n = 1'b0;
    seg_invert = 1'b0;
    #1;
    chk("inv_comb_sel", {6'b0, digit_sel}, 8'h00);
    chk("inv_comb_seg", {1'b0, segments}, 8'h00);

    // Scan timing, update latency A7, backpressure on 34
    do_reset(2);
    for (int k = 1; k <= 64; k++) begin
      step(k == 5 || k == 6, (k == 5) ? 8'hA7 : 8'h34);
      case (k)
        2:  chk("scan_e2", {6'b0, digit_sel}, 8'h00);
        3:  begin chk("scan_e3", {6'b0, digit_sel}, 8'h01); chk("scan_e3_seg", {1'b0, segments}, 8'h3F); end
        16: chk("scan_e16", {6'b0, digit_sel}, 8'h01);
        17: chk("scan_e17", {6'b0, digit_sel}, 8'h00);
        19: chk("scan_e19", {6'b0, digit_sel}, 8'h02);
        31: chk("busy_e31", {7'b0, in_ready}, 8'h00);
        32: begin chk("tick_e32", {7'b0, frame_tick}, 8'h01); chk("ready_e32", {7'b0, in_ready}, 8'h01); end
        35: chk("upd_d0", {1'b0, segments}, 8'h07);
        51: chk("upd_d1", {1'b0, segments}, 8'h77);
        default: ;
      endcase
    end

    // 12 then 34 back to back; mid-operation reset with a pending value
    do_reset(2);
    for (int k = 1; k <= 52; k++) begin
      step(k <= 2 || k == 45, (k == 1) ? 8'h12 : ((k == 2) ? 8'h34 : 8'h9C));
      if (k == 35) chk("bp_d0", {1'b0, segments}, 8'h5B);
      if (k == 51) chk("bp_d1", {1'b0, segments}, 8'h06);
    end
    chk("pend_before_rst", {7'b0, in_ready}, 8'h00);
    do_reset(1);
    for (int k = 1; k <= 36; k++) begin
      step(1'b0, 8'h00);
      if (k == 2)  chk("rs_e2", {6'b0, digit_sel}, 8'h00);
      if (k == 3)  chk("rs_e3", {1'b0, segments}, 8'h3F);
      if (k == 19) chk("rs_e19", {6'b0, digit_sel}, 8'h02);
      if (k == 35) chk("rs_disp00", {1'b0, segments}, 8'h3F);
    end

    // Polarity with disp=05
    do_reset(1);
    seg_invert = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step(k == 1, 8'h05);
      if (k == 33) begin chk("inv_blank_sel", {6'b0, digit_sel}, 8'h03); chk("inv_blank_seg", {1'b0, segments}, 8'h7F); end
      if (k == 35) begin chk("inv_sel", {6'b0, digit_sel}, 8'h02); chk("inv_seg", {1'b0, segments}, 8'h12); end
    end
    seg_invert = 1'b0;

    // Leading-zero suppression and blink with disp=08
    do_reset(1);
    lz_en = 1'b1; blink = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      step(k == 1, 8'h08);
      if (k == 70)  chk("lz_d0", {1'b0, segments}, 8'h7F);
      if (k == 86)  chk("lz_d1", {1'b0, segments}, 8'h00);
      if (k == 646) begin chk("blink_off_seg", {1'b0, segments}, 8'h00); chk("blink_off_sel", {6'b0, digit_sel}, 8'h01); end
      if (k == 1030) chk("blink_on_again", {1'b0, segments}, 8'h7F);
    end

    // Random traffic
    do_reset(1);
    lz_en = 1'b0; blink = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if ($urandom_range(0, 15) == 0) seg_invert = ~seg_invert;
      if ($urandom_range(0, 99) == 0) lz_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 199) == 0) blink = $urandom_range(0, 1) == 1;
      step($urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
